// File: rtl/face_pkg.sv
// rtl/face_pkg.sv - shared face geometry, state encoding and cell index helper
package face_pkg;

    localparam int N_ROWS  = 3;
    localparam int N_COLS  = 3;
    localparam int N_CELLS = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Linear cell index row*N_COLS+col; the largest value is 8, which fits in 4 bits
    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'(N_COLS)) + {2'b00, col};
    endfunction

endpackage

// File: rtl/cell_counter.sv
// rtl/cell_counter.sv - row/column stepper for the 3x3 face walk
module cell_counter
    import face_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic       clear,
    input  logic       step,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       col_wrap,
    output logic       last
);

    // Only the final column and the final cell are of interest to the FSM
    always_comb begin
        col_wrap = (col == 2'(N_COLS - 1));
        last     = col_wrap && (row == 2'(N_ROWS - 1));
    end

    // Column advances first and carries into the row; the last cell wraps to 0,0 so 3 is never presented
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            row <= 2'd0;
            col <= 2'd0;
        end else if (clear) begin
            row <= 2'd0;
            col <= 2'd0;
        end else if (step) begin
            if (col_wrap) begin
                col <= 2'd0;
                row <= last ? 2'd0 : row + 2'd1;
            end else begin
                col <= col + 2'd1;
            end
        end
    end

endmodule

// File: rtl/face_reader.sv
// rtl/face_reader.sv - streams one 3x3 face from RAM; FACE_READER_CHECKSUM_EN adds out_sum
module face_reader
    import face_pkg::*;
#(
    parameter int S_DATA = 16
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic              abort,
    output logic [1:0]        addr1,
    output logic [1:0]        addr2,
    input  logic [S_DATA-1:0] ram_q,
    output logic [S_DATA-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef FACE_READER_CHECKSUM_EN
    ,
    output logic [S_DATA-1:0] out_sum
`endif
);

    state_t     state;
    state_t     state_nxt;
    logic       cnt_clear;
    logic       cnt_step;
    logic       cap_en;
    logic [1:0] row;
    logic [1:0] col;
    logic       col_wrap;
    logic       last_cell;

    cell_counter u_cell_counter (
        .clk      (clk),
        .clear_n  (clear_n),
        .clear    (cnt_clear),
        .step     (cnt_step),
        .row      (row),
        .col      (col),
        .col_wrap (col_wrap),
        .last     (last_cell)
    );

    // Counters sit at 0,0 whenever the block is idle, so the addresses can follow them directly
    always_comb begin
        addr1     = row;
        addr2     = col;
        out_valid = (state == ST_SEND);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
    end

    // State register
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and counter/capture controls; abort overrides start and out_ready
    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        cap_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!abort && start) begin
                    state_nxt = ST_READ;
                    cnt_clear = 1'b1;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    state_nxt = ST_SEND;
                    cap_en    = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_clear = 1'b1;
                end else if (out_ready) begin
                    if (last_cell) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_READ;
                        cnt_step  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_clear = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // Output beat register: loaded once in READ and held through the SEND handshake
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_data <= '0;
            out_idx  <= 4'd0;
            out_last <= 1'b0;
        end else if (cap_en) begin
            out_data <= ram_q;
            out_idx  <= cell_index(row, col);
            out_last <= last_cell;
        end
    end

`ifdef FACE_READER_CHECKSUM_EN
    logic sum_clear;
    logic sum_add;

    always_comb begin
        sum_clear = ((state == ST_IDLE) && start && !abort) || ((state != ST_IDLE) && abort);
        sum_add   = (state == ST_SEND) && out_ready && !abort;
    end

    // Running modulo-2^S_DATA sum of accepted beats; final value is visible while done is high
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_sum <= '0;
        end else if (sum_clear) begin
            out_sum <= '0;
        end else if (sum_add) begin
            out_sum <= out_sum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_face_reader.sv
// tb/tb_face_reader.sv - directed self-checking bench for face_reader
module tb_face_reader;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        start;
    logic        abort;
    logic [1:0]  addr1;
    logic [1:0]  addr2;
    logic [15:0] ram_q;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef FACE_READER_CHECKSUM_EN
    logic [15:0] out_sum;
`endif

    logic [15:0] mem [9];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    face_reader #(.S_DATA(16)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .abort     (abort),
        .addr1     (addr1),
        .addr2     (addr2),
        .ram_q     (ram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef FACE_READER_CHECKSUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    always_comb begin
        ram_q = mem[int'(addr1) * 3 + int'(addr2)];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_idx"},   32'(out_idx),   32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_addr"},  32'({addr1, addr2}), 32'd0);
    endtask

    // Called just after a rising edge; start is sampled at the next edge (cycle N), cyc counts from N
    task automatic run_face(input int stall_idx, input int stall_len, input int restart_at,
                            output int beats, output int first_cyc, output int done_cyc);
        int cyc;
        int stalled;
        beats = 0; first_cyc = -1; done_cyc = -1; stalled = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 80 && done_cyc < 0) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == restart_at);
            if (done) begin
                done_cyc = cyc;
            end else if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (int'(out_idx) == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                    check("stall_data", 32'(out_data), 32'(mem[stall_idx]));
                    check("stall_addr", 32'({addr1, addr2}), 32'(((stall_idx / 3) << 2) | (stall_idx % 3)));
                end else begin
                    out_ready = 1'b1;
                    if (beats > 8) begin
                        check("extra_beat", 32'(beats), 32'd8);
                    end else begin
                        check("beat_data", 32'(out_data), 32'(mem[beats]));
                        check("beat_idx",  32'(out_idx),  32'(beats));
                        check("beat_last", 32'(out_last), 32'(beats == 8));
                    end
                    beats++;
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Runs until the beat with index idx is on the bus, or flags a timeout
    task automatic wait_beat(input int idx, input string tag);
        int n;
        logic hit;
        hit = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (n = 0; n < 40 && !hit; n++) begin
            @(posedge clk); #1;
            if (out_valid && int'(out_idx) == idx) hit = 1'b1;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        int beats, first_cyc, done_cyc, seen;
        clear_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 9; k++) mem[k] = 16'h0A00 + 16'(k);

        #2;
        check_all_zero("reset");
        @(negedge clk); clear_n = 1'b1;
        @(posedge clk); #1;

        // Basic face, ready tied high
        run_face(-1, 0, -1, beats, first_cyc, done_cyc);
        check("t1_beats", 32'(beats), 32'd9);
        check("t1_first", 32'(first_cyc), 32'd2);
        check("t1_done_cyc", 32'(done_cyc), 32'd19);
`ifdef FACE_READER_CHECKSUM_EN
        check("t1_sum", 32'(out_sum), 32'h5A24);
`endif
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Backpressure on idx 4 for five cycles
        run_face(4, 5, -1, beats, first_cyc, done_cyc);
        check("t2_beats", 32'(beats), 32'd9);
        check("t2_done_cyc", 32'(done_cyc), 32'd24);
        @(posedge clk); #1;

        // Start re-pulsed while busy
        run_face(-1, 0, 5, beats, first_cyc, done_cyc);
        check("t3_beats", 32'(beats), 32'd9);
        check("t3_done_cyc", 32'(done_cyc), 32'd19);
        @(posedge clk); #1;
        check("t3_idle", 32'(busy), 32'd0);

        // Abort during SEND of idx 6, with out_ready also high
        wait_beat(6, "t4_reach6");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_busy",  32'(busy), 32'd0);
        check("t4_addr",  32'({addr1, addr2}), 32'd0);
`ifdef FACE_READER_CHECKSUM_EN
        check("t4_sum", 32'(out_sum), 32'd0);
`endif
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (done || out_valid) seen++;
        end
        check("t4_quiet", 32'(seen), 32'd0);
        run_face(-1, 0, -1, beats, first_cyc, done_cyc);
        check("t4_beats", 32'(beats), 32'd9);
        check("t4_first", 32'(first_cyc), 32'd2);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of idx 3
        wait_beat(3, "t5_reach3");
        #2 clear_n = 1'b0;
        #1 check_all_zero("t5_async");
        @(negedge clk); clear_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (busy || out_valid || done) seen++;
        end
        check("t5_quiet", 32'(seen), 32'd0);
        run_face(-1, 0, -1, beats, first_cyc, done_cyc);
        check("t5_beats", 32'(beats), 32'd9);
        check("t5_done_cyc", 32'(done_cyc), 32'd19);
        @(posedge clk); #1;

`ifdef FACE_READER_CHECKSUM_EN
        // Checksum wraps modulo 2^16: 9 * 0xFFFF = 0x8FFF7
        for (int k = 0; k < 9; k++) mem[k] = 16'hFFFF;
        run_face(-1, 0, -1, beats, first_cyc, done_cyc);
        check("t6_beats", 32'(beats), 32'd9);
        check("t6_sum", 32'(out_sum), 32'hFFF7);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/face_reader.md
FACE_READER -- requirements
Module: face_reader

Interface
REQ-001 Parameter: S_DATA, default 16, width of one stored cell value.
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 clear_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to stream one full 3x3 face.
REQ-005 abort  input  1  cancels an in-progress read.
REQ-006 addr1  output  2  row address driven to the 3x3 face RAM.
REQ-007 addr2  output  2  column address driven to the 3x3 face RAM.
REQ-008 ram_q  input  S_DATA  combinational RAM read data for (addr1, addr2).
REQ-009 out_data  output  S_DATA  captured cell value.
REQ-010 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-011 out_ready  input  1  consumer accepts the beat when high with out_valid.
REQ-012 out_idx  output  4  linear cell index 0..8, equal to row*3+col.
REQ-013 out_last  output  1  high with out_valid on cell 8 only.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after cell 8 is accepted.

Function
REQ-016 FSM states SHALL be IDLE, READ, SEND and DONE.
REQ-017 IDLE: addr1=addr2=0; start=1 moves to READ with row=col=0.
REQ-018 READ, one cycle: addr1=row, addr2=col; ram_q is captured into out_data, and out_idx/out_last are registered; next state SEND.
REQ-019 SEND: out_valid=1; out_data, out_idx and out_last are held stable until out_valid and out_ready are both high.
REQ-020 On acceptance of a non-last cell: col increments; col 2 wraps to 0 with row+1; next state READ.
REQ-021 On acceptance of cell 8 (row 2, col 2): next state DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 Latency: start in cycle N gives first out_valid in cycle N+2; with out_ready tied high a face takes 18 cycles and done is asserted in cycle N+19.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort in READ, SEND or DONE SHALL go to IDLE on the next edge: out_valid=0, no done pulse, counters cleared; abort has priority over out_ready in the same cycle.
REQ-026 start and abort both high in IDLE: abort wins, and the block stays in IDLE.
REQ-027 out_valid SHALL never be high outside SEND.
REQ-028 Row and column addresses SHALL never present the value 3.

Reset
REQ-029 clear_n low SHALL force state IDLE, row=col=0, addr1=addr2=0, out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0 and done=0, immediately and independent of clk.
REQ-030 Reset asserted mid-face SHALL discard the face; after release the block waits for a new start.

Configuration
REQ-031 Macro FACE_READER_CHECKSUM_EN: when defined, adds output out_sum [S_DATA-1:0], the modulo-2^S_DATA sum of the nine accepted cells.
REQ-032 out_sum is cleared on start, updated on each accepted beat, valid while done=1, reset to 0 and cleared by abort.
REQ-033 Without FACE_READER_CHECKSUM_EN: no out_sum port and no adder logic.

Structure
REQ-034 Shared package face_pkg SHALL hold N_ROWS=3, N_COLS=3, N_CELLS=9 and the state encoding typedef.
REQ-035 Row/column stepping SHALL be a sub-module cell_counter with clear, step and wrap outputs; the FSM and output register stay in face_reader.

Verification
REQ-036 RAM model with cell k = 16'h0A00+k, out_ready=1, pulse start -> beats 0x0A00..0x0A08, idx 0..8, out_last only on idx 8, done in cycle N+19.
REQ-037 out_ready low for 5 cycles on idx 4 -> out_data=0x0A04 held stable and addresses unchanged; resumes correctly at idx 5.
REQ-038 abort during SEND of idx 6 -> out_valid=0 next cycle, no done, busy=0; a new start returns idx 0 first.
REQ-039 clear_n pulsed low during idx 3 -> all outputs 0 asynchronously; no beats until a new start.
REQ-040 start re-pulsed while busy -> sequence unaffected, exactly 9 beats.
REQ-041 With FACE_READER_CHECKSUM_EN and cells all 16'hFFFF -> out_sum=16'hFFF7 during done.
